// File: rtl/m_call_accum_stage_pkg.sv
// Shared types, saturation bounds and constant helper functions for the
// biased saturating frame accumulator.
package m_call_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } state_e;

  localparam int INT_MAX = 32'h7FFF_FFFF;
  localparam int INT_MIN = 32'h8000_0000;

  // Bias applied to every sample, derived from a seed value at elaboration.
  function automatic int bias_of(input int seed);
    return seed + 1;
  endfunction

  // Bits needed to hold values 0..n, i.e. ceil(log2(n+1)).
  function automatic int cnt_width(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n + 1) w = i + 1;
    end
    return w;
  endfunction

  // Signed add that clamps to INT_MAX/INT_MIN instead of wrapping.
  function automatic int sat_add(input int a, input int b, output bit ovf);
    logic signed [32:0] s;
    s   = {a[31], a} + {b[31], b};
    ovf = 1'b0;
    if (s[32] != s[31]) begin
      ovf = 1'b1;
      return s[32] ? INT_MIN : INT_MAX;
    end
    return int'(s[31:0]);
  endfunction

endpackage

// File: rtl/m_call_accum_stage_if.sv
// Sample-in / frame-result-out bundle for m_call_accum_stage.
// Optional out_parity exists only when M_CALL_ACCUM_PARITY_EN is defined.
interface m_call_accum_stage_if;

  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] out_data;
  logic               out_ovf;
  logic [15:0]        frame_cnt;
`ifdef M_CALL_ACCUM_PARITY_EN
  logic               out_parity;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, frame_cnt, out_parity
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ovf, frame_cnt, out_parity
  );
`else
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, frame_cnt
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ovf, frame_cnt
  );
`endif

endinterface

// File: rtl/m_call_accum_stage_sat_adder.sv
// Combinational saturating adder; feeds the accumulator register.
module m_call_sat_adder
  import m_call_pkg::*;
(
  input  logic signed [31:0] a_i,
  input  logic signed [31:0] b_i,
  output logic signed [31:0] sum_o,
  output logic               ovf_o
);

  // Clamp the sum and flag when clamping happened.
  always_comb begin
    ovf_o = 1'b0;
    sum_o = sat_add(a_i, b_i, ovf_o);
  end

endmodule

// File: rtl/m_call_accum_stage.sv
// Biased saturating frame accumulator: sums ACC_LEN accepted samples
// (each plus BIAS), then presents the frame result until taken.
// Optional feature macro: M_CALL_ACCUM_PARITY_EN adds out_parity = ^out_data.
//
// state | meaning
// ACCUM | accepting samples, in_ready=1
// EMIT  | frame result held on out_*, waiting for out_ready
module m_call_accum_stage
  import m_call_pkg::*;
#(
  parameter int ACC_LEN = 4,
  parameter int BIAS    = bias_of(5)
) (
  input  logic                 clk,
  input  logic                 rst,
  m_call_accum_stage_if.slave  bus_if
);

  localparam int             CNT_W    = cnt_width(ACC_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);

  state_e             state_q, state_d;
  logic signed [31:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic signed [31:0] out_data_q, out_data_d;
  logic               out_ovf_q, out_ovf_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic signed [31:0] biased;
  logic               bias_ovf;
  logic signed [31:0] sum;
  logic               add_ovf;
  logic               accept;
`ifdef M_CALL_ACCUM_PARITY_EN
  logic               par_q, par_d;
`endif

  // Frame bookkeeping reset back to an empty accumulator.
  function automatic void clear_frame(output logic signed [31:0] acc,
                                      output logic [CNT_W-1:0]   cnt,
                                      output logic               ovf);
    acc = '0;
    cnt = '0;
    ovf = 1'b0;
  endfunction

  // Completed-frame counter advance; wraps naturally at 16 bits.
  task automatic bump_frame(input logic [15:0] cur, output logic [15:0] nxt);
    nxt = cur + 16'd1;
  endtask

`ifdef M_CALL_ACCUM_PARITY_EN
  function automatic void calc_par(input int v, output bit p);
    p = ^v;
  endfunction
`endif

  // Bias the incoming sample, clamping rather than wrapping.
  always_comb begin
    bias_ovf = 1'b0;
    biased   = sat_add(bus_if.in_data, BIAS, bias_ovf);
  end

  m_call_sat_adder u_sat_adder (
    .a_i   (acc_q),
    .b_i   (biased),
    .sum_o (sum),
    .ovf_o (add_ovf)
  );

  assign accept = (state_q == ACCUM) && bus_if.in_valid;

  // Next-state, accumulation and result capture.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    frame_cnt_d = frame_cnt_q;
`ifdef M_CALL_ACCUM_PARITY_EN
    par_d       = par_q;
`endif
    case (state_q)
      ACCUM: begin
        if (accept) begin
          acc_d = sum;
          ovf_d = ovf_q | bias_ovf | add_ovf;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d    = EMIT;
            out_data_d = sum;
            out_ovf_d  = ovf_q | bias_ovf | add_ovf;
`ifdef M_CALL_ACCUM_PARITY_EN
            calc_par(sum, par_d);
`endif
          end
        end
      end
      EMIT: begin
        if (bus_if.out_ready) begin
          state_d = ACCUM;
          clear_frame(acc_d, cnt_d, ovf_d);
          bump_frame(frame_cnt_q, frame_cnt_d);
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

`ifdef M_CALL_ACCUM_PARITY_EN
  // Parity of the captured result, registered alongside out_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) par_q <= 1'b0;
    else     par_q <= par_d;
  end

  assign bus_if.out_parity = par_q;
`endif

  assign bus_if.in_ready  = (state_q == ACCUM);
  assign bus_if.out_valid = (state_q == EMIT);
  assign bus_if.out_data  = out_data_q;
  assign bus_if.out_ovf   = out_ovf_q;
  assign bus_if.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_m_call_accum_stage.sv
// Directed bench for m_call_accum_stage with ACC_LEN=4, BIAS=6.
module tb_m_call_accum_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  m_call_accum_stage_if bus ();

  m_call_accum_stage dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus)
  );

  int checks = 0;
  int errors = 0;
  int exp_frames = 0;

  typedef struct {
    logic [31:0] d0, d1, d2, d3;
    logic [31:0] exp_data;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [31:0] v);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    @(negedge clk);
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) chk("send_timeout", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame(input string nm,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] d,
                       input int gap,
                       input logic [31:0] exp, input logic exp_ovf);
    bus.out_ready = 1'b1;
    send(a); if (gap > 0) idle(gap);
    send(b); if (gap > 0) idle(gap);
    send(c); if (gap > 0) idle(gap);
    chk({nm, "_early"}, {31'd0, bus.out_valid}, 32'd0);
    send(d);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    chk({nm, "_data"}, bus.out_data, exp);
    chk({nm, "_ovf"}, {31'd0, bus.out_ovf}, {31'd0, exp_ovf});
    chk({nm, "_inrdy"}, {31'd0, bus.in_ready}, 32'd0);
`ifdef M_CALL_ACCUM_PARITY_EN
    chk({nm, "_par"}, {31'd0, bus.out_parity}, {31'd0, ^exp});
`endif
    @(posedge clk);
    #1;
    exp_frames++;
    chk({nm, "_fcnt"}, {16'd0, bus.frame_cnt}, exp_frames);
    chk({nm, "_done"}, {31'd0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Hand-computed frame sums; each sample carries +6 before accumulation.
    vecs[0] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd34, 1'b0};
    vecs[1] = '{32'h7FFF_FFF0, 32'h7FFF_FFF0, 32'h7FFF_FFF0, 32'h7FFF_FFF0, 32'h7FFF_FFFF, 1'b1};
    vecs[2] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1'b1};
    vecs[3] = '{32'hFFFF_FFFA, 32'hFFFF_FFFA, 32'hFFFF_FFFA, 32'hFFFF_FFFA, 32'd0, 1'b0};
    vecs[4] = '{32'd10, 32'hFFFF_FFEC, 32'd30, 32'hFFFF_FFD8, 32'd4, 1'b0};
    vecs[5] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd24, 1'b0};
    vecs[6] = '{32'h7FFF_FFF0, 32'h7FFF_FFF0, 32'h8000_0000, 32'h8000_0000, 32'h8000_000B, 1'b1};

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    #12;
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_data", bus.out_data, 32'd0);
    chk("rst_ovf", {31'd0, bus.out_ovf}, 32'd0);
    chk("rst_fcnt", {16'd0, bus.frame_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_inrdy", {31'd0, bus.in_ready}, 32'd1);

    for (int i = 0; i < 7; i++) begin
      frame($sformatf("vec%0d", i), vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].d3,
            0, vecs[i].exp_data, vecs[i].exp_ovf);
    end

    // Stall in EMIT: result must hold and incoming samples must be ignored.
    bus.out_ready = 1'b0;
    send(32'd1); send(32'd2); send(32'd3); send(32'd4);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'd100 + i;
      @(negedge clk);
      chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("stall_inrdy", {31'd0, bus.in_ready}, 32'd0);
      chk("stall_data", bus.out_data, 32'd34);
      chk("stall_ovf", {31'd0, bus.out_ovf}, 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    exp_frames++;
    chk("stall_fcnt", {16'd0, bus.frame_cnt}, exp_frames);
    frame("post_stall", 32'd1, 32'd2, 32'd3, 32'd4, 0, 32'd34, 1'b0);

    // Gaps in in_valid between samples.
    frame("gaps", 32'd1, 32'd2, 32'd3, 32'd4, 2, 32'd34, 1'b0);

    // Reset mid-frame discards the partial sum.
    send(32'd100);
    send(32'd200);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_data", bus.out_data, 32'd0);
    chk("midrst_fcnt", {16'd0, bus.frame_cnt}, 32'd0);
    chk("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_frames = 0;
    @(posedge clk);
    #1;
    chk("midrst_inrdy", {31'd0, bus.in_ready}, 32'd1);
    frame("after_rst", 32'd1, 32'd1, 32'd1, 32'd1, 0, 32'd28, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
